// File: rtl/alu_ctrl_pkg.sv
// Shared constants, state/extension enums and the immediate extension helper
// for the ALU control sequencer.
package alu_ctrl_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_AND  = 6'b000010;
    localparam logic [5:0] ALU_NOR  = 6'b000011;
    localparam logic [5:0] ALU_OR   = 6'b000100;
    localparam logic [5:0] ALU_SLT  = 6'b000101;
    localparam logic [5:0] ALU_ADDI = 6'b000110;
    localparam logic [5:0] ALU_ANDI = 6'b000111;
    localparam logic [5:0] ALU_SUBI = 6'b001000;
    localparam logic [5:0] ALU_ORI  = 6'b001001;
    localparam logic [5:0] ALU_SLTI = 6'b001101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SUBI  = 6'h18;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
    typedef enum logic {ZERO, SIGN} ext_t;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_t ext);
        return (ext == SIGN) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder: opcode/funct to ALU code and controls.
// Immediate opcodes decode only when ALU_CTRL_IMM_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [5:0] alu_code,
    output logic       alu_src,
    output ext_t       ext_sel,
    output logic       wr_rt,
    output logic       illegal
);

    always_comb begin
        alu_code = ALU_ADD;
        alu_src  = 1'b0;
        ext_sel  = SIGN;
        wr_rt    = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_code = ALU_ADD;
                    FN_SUB:  alu_code = ALU_SUB;
                    FN_AND:  alu_code = ALU_AND;
                    FN_OR:   alu_code = ALU_OR;
                    FN_NOR:  alu_code = ALU_NOR;
                    FN_SLT:  alu_code = ALU_SLT;
                    default: illegal  = 1'b1;
                endcase
            end
`ifdef ALU_CTRL_IMM_EN
            OP_ADDI: begin alu_code = ALU_ADDI; alu_src = 1'b1; wr_rt = 1'b1; end
            OP_SLTI: begin alu_code = ALU_SLTI; alu_src = 1'b1; wr_rt = 1'b1; end
            OP_SUBI: begin alu_code = ALU_SUBI; alu_src = 1'b1; wr_rt = 1'b1; end
            OP_ANDI: begin alu_code = ALU_ANDI; alu_src = 1'b1; wr_rt = 1'b1; ext_sel = ZERO; end
            OP_ORI:  begin alu_code = ALU_ORI;  alu_src = 1'b1; wr_rt = 1'b1; ext_sel = ZERO; end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Multi-cycle ALU control front end: accepts one instruction, steps it through
// DECODE/EXEC/WB and strobes reg_write. Immediate support: ALU_CTRL_IMM_EN.
module alu_ctrl_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter bit IDLE_READY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        flush,
    output logic [5:0]  alu_control_out,
    output logic        alu_src,
    output logic [31:0] imm_ext,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic        illegal,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge where
    // instr_valid && instr_ready; instr must be stable while instr_valid is high.

    state_t      state;
    logic        reg_write_q;
    logic        illegal_q;
    logic [5:0]  dec_code;
    logic        dec_src;
    ext_t        dec_ext;
    logic        dec_wr_rt;
    logic        dec_illegal;
    logic        accept;
    logic [31:0] imm_d;

    alu_ctrl_decode u_decode (
        .opcode   (instr[31:26]),
        .funct    (instr[5:0]),
        .alu_code (dec_code),
        .alu_src  (dec_src),
        .ext_sel  (dec_ext),
        .wr_rt    (dec_wr_rt),
        .illegal  (dec_illegal)
    );

    assign instr_ready = (state == IDLE) && IDLE_READY && !flush;
    assign accept      = instr_valid && instr_ready;
    // R-type (and every opcode when immediates are disabled) yields alu_src=0, so imm_ext is 0.
    assign imm_d       = dec_src ? extend_imm(instr[15:0], dec_ext) : 32'h0;

    // A flush landing on the strobe cycle must cancel it within the same cycle.
    assign reg_write = reg_write_q && !flush;
    assign illegal   = illegal_q && !flush;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Decoding happens at the accept edge so illegal is visible during DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            alu_control_out <= 6'b000000;
            alu_src         <= 1'b0;
            imm_ext         <= 32'h0;
            rs_addr         <= 5'd0;
            rt_addr         <= 5'd0;
            write_reg       <= 5'd0;
            reg_write_q     <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= DECODE;
                        if (dec_illegal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            alu_control_out <= dec_code;
                            alu_src         <= dec_src;
                            imm_ext         <= imm_d;
                            rs_addr         <= instr[25:21];
                            rt_addr         <= instr[20:16];
                            write_reg       <= dec_wr_rt ? instr[20:16] : instr[15:11];
                        end
                    end
                end
                DECODE: begin
                    if (flush || illegal_q) state <= IDLE;
                    else                    state <= EXEC;
                end
                EXEC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        state       <= WB;
                        reg_write_q <= (write_reg != 5'd0);
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_ctrl_sequencer.md
# alu_ctrl_sequencer

Multi-cycle control front end that issues instructions to the datapath ALU. It accepts one 32-bit MIPS-style instruction through a valid/ready handshake and decodes it into the 6-bit ALU operation code plus operand and writeback controls. It then steps the instruction through DECODE, EXEC and WB states and raises a one-cycle register write strobe. It sits between the instruction fetch stage and the ALU / register file, and is the producer of `alu_control_out`.

## Interface
- `IDLE_READY`, default 1: when 1, `instr_ready` is asserted in IDLE; when 0, the block ignores all instructions (bring-up hold).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_valid` input 1: `instr` is valid.
- `instr` input 32: instruction word.
- `instr_ready` output 1: equals (state==IDLE) && IDLE_READY && !flush.
- `flush` input 1: synchronous abort of the in-flight instruction.
- `alu_control_out` output 6: ALU operation code, valid in EXEC and WB.
- `alu_src` output 1: 1 means the ALU operand B is `imm_ext`; 0 means it is register rt.
- `imm_ext` output 32: extended immediate.
- `rs_addr` output 5, `rt_addr` output 5: register file read addresses.
- `reg_write` output 1: one-cycle write strobe.
- `write_reg` output 5: write address; rd for R-type, rt for immediate instructions.
- `illegal` output 1: one-cycle pulse on an unsupported encoding.
- `busy` output 1: state != IDLE.

## Operation
- **Codes:**
  - ADD 000000, SUB 000001, AND 000010, NOR 000011, OR 000100, SLT 000101.
  - ADDI 000110, ANDI 000111, SUBI 001000, ORI 001001, SLTI 001101.
- **R-type:** opcode 0x00, selected by funct.
  - add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, slt 0x2A.
  - Any other funct is illegal.
- **Immediate opcodes:** addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, subi 0x18. Any other opcode is illegal.
- **Immediate extension:**
  - andi and ori zero-extend imm[15:0].
  - All other immediate instructions sign-extend.
  - R-type drives `imm_ext`=0 and `alu_src`=0.
- **States:** IDLE → DECODE → EXEC → WB → IDLE.
  - IDLE → DECODE on `instr_valid && instr_ready`; the instruction is captured into a register.
  - DECODE: decoder outputs are registered. An illegal instruction pulses `illegal` and returns to IDLE; otherwise the block goes to EXEC.
  - EXEC: `alu_control_out`, `alu_src`, `imm_ext` and the register addresses are stable; the ALU result settles this cycle.
  - WB: `reg_write`=1 for exactly one cycle, unless `write_reg`==0, in which case the strobe is suppressed. Then → IDLE.
- **flush:** in any non-IDLE state, the next state is IDLE, with no `reg_write` and no `illegal`. A flush in WB suppresses that cycle's `reg_write`.
- **Register hold:** decode outputs hold their last values in IDLE. Only `reg_write` and `illegal` return to 0.

## Timing
- **Latency:** accept at cycle N; `illegal` at N+1 (DECODE); EXEC at N+2; `reg_write` at N+3.
- **Throughput:** one instruction per 4 cycles. `instr_ready` reasserts at N+4, or at N+2 after an illegal instruction.
- **Reset values:** all registered outputs are 0 (`alu_control_out`=000000, `alu_src` 0, `imm_ext` 0, addresses 0, `reg_write` 0, `illegal` 0, `busy` 0). State is IDLE.
- **After reset:** `instr_ready`=1 in the first cycle after `reset` deasserts (when IDLE_READY=1).
- **Reset mid-operation:** the in-flight instruction is aborted and no strobe is issued.
- **Simultaneous flush and instr_valid in IDLE:** flush wins and the instruction is not accepted.

## Configuration
- `ALU_CTRL_IMM_EN` defined: all five immediate opcodes decode as specified.
- `ALU_CTRL_IMM_EN` undefined: only R-type decodes. Every immediate opcode pulses `illegal`, `alu_src` is tied 0, and `imm_ext` is tied 0.

## Structure
- **Package `alu_ctrl_pkg`:**
  - The 11 ALU code constants.
  - Opcode and funct constants.
  - State enum: IDLE, DECODE, EXEC, WB.
  - Extension-type enum: ZERO, SIGN.
- **Sub-module `alu_ctrl_decode`:** purely combinational. Maps `instr` to code, `alu_src`, extension type, `write_reg` select and illegal.
- **Top level:** holds the FSM and the output registers.

## Test plan
- Send `instr` 0x00221820 (add $3,$1,$2). EXEC shows `alu_control_out`=000000 with `rs_addr`=1 and `rt_addr`=2. `reg_write`=1 at N+3 with `write_reg`=3.
- Send 0x30858000 (andi $5,$4,0x8000). Expect code 000111, `alu_src`=1, `imm_ext`=0x00008000, `write_reg`=5. Then send 0x2085FFFF (addi). Expect code 000110 and `imm_ext`=0xFFFFFFFF.
- Send 0x00221821 (funct 0x21). `illegal` pulses at N+1, no `reg_write`, `instr_ready`=1 at N+2.
- Assert `flush` during EXEC of 0x00221820. No `reg_write` occurs and `instr_ready`=1 the next cycle. Assert `reset` during DECODE. All outputs are 0 and no strobe is issued.
- Send 0x00220020 (rd=0). The full sequence runs with `reg_write` held 0.
- With `ALU_CTRL_IMM_EN` undefined, send 0x2085FFFF. `illegal` pulses at N+1 and `alu_src` stays 0.
